digit_scan: RTL

//  Time-multiplexes NUM_DIGITS 4-bit digit values onto one 4-bit nibble bus and a one-hot digit-enable bus.

---
 rtl/digit_scan_pkg.sv | 15 +
 rtl/digit_scan_tick_gen.sv | 31 +++
 rtl/digit_scan.sv | 127 ++++++++++++
 3 files changed

// File: rtl/digit_scan_pkg.sv
// Shared definitions for the digit scanner and its companion display blocks.
// SEG_* constants are shared with seven_seg.
package digit_scan_pkg;

  localparam int unsigned SEG_NIBBLE_W = 4;
  localparam logic        SEG_BLANK    = 1'b0;

  // Source of a display-register update at a frame boundary.
  typedef enum logic [1:0] {
    XFER_NONE   = 2'd0,
    XFER_SHADOW = 2'd1,
    XFER_BYPASS = 2'd2
  } xfer_e;

endpackage

// File: rtl/digit_scan_tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every DIV.
module tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  assign tick = (presc_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/digit_scan.sv
// Time-multiplexed digit scanner with frame-synchronous double buffering.
// Optional LEADING_ZERO_BLANK_EN suppresses the anodes of leading zero digits.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 1000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load,
  input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0] digits_in,
  output logic [SEG_NIBBLE_W-1:0]            nibble,
  output logic [NUM_DIGITS-1:0]              an,
  output logic                               ack
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = SEG_NIBBLE_W * NUM_DIGITS;

  logic              tick;
  logic              frame_end;
  xfer_e             xfer;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              ack_q, ack_d;
  logic [NUM_DIGITS-1:0] blank;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_end = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A load landing on frame_end goes straight to disp so it is not lost a frame.
  always_comb begin
    xfer = XFER_NONE;
    if (frame_end) begin
      if (load) begin
        xfer = XFER_BYPASS;
      end else if (pending_q) begin
        xfer = XFER_SHADOW;
      end
    end
  end

  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end
    case (xfer)
      XFER_BYPASS: begin
        disp_d    = digits_in;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
      XFER_SHADOW: begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      int unsigned j;
      j = NUM_DIGITS - 1 - k;
      upper_zero = upper_zero & (disp_q[SEG_NIBBLE_W*j +: SEG_NIBBLE_W] == '0);
      if (j != 0) begin
        blank[j] = upper_zero;
      end
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    an = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      an[k] = ((idx_q == IDX_W'(k)) && !blank[k]) ? ~SEG_BLANK : SEG_BLANK;
    end
  end

  assign nibble = disp_q[SEG_NIBBLE_W*idx_q +: SEG_NIBBLE_W];
  assign ack    = ack_q;

endmodule
